// File: rtl/rmii_rx_framer.sv
// RMII/MII receive framer: hunts preamble/SFD, writes LSB-first bytes plus one
// status trailer per frame to the RX FIFO, and keeps gray-coded monitor counters.
module rmii_rx_framer #(
  parameter int DW      = 2,
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518,
  parameter int CNT_W   = 16
) (
  input  logic             REF_CLK,
  input  logic             arst,
  input  logic             CRS,
  input  logic [DW-1:0]    RXD,
  input  logic             fifo_afull,
  output logic [7:0]       fifo_din,
  output logic             fifo_wren,
  output logic             fifo_EOD_in,
  output logic [CNT_W-1:0] succ_rx_count_gray,
  output logic [CNT_W-1:0] buff_OF_count_gray,
  output logic [CNT_W-1:0] crc_err_count_gray,
  output logic [CNT_W-1:0] len_err_count_gray
);

  localparam logic [1:0]  PH_LAST     = 2'(8 / DW - 1);
  localparam logic [10:0] MIN_L       = 11'(MIN_LEN);
  localparam logic [10:0] MAX_L       = 11'(MAX_LEN);
  localparam logic [7:0]  SFD         = 8'hD5;
  localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_BODY, S_END, S_DROP} state_t;

  state_t           r_state;
  logic [7:0]       r_sh;
  logic [1:0]       r_phase;
  logic [10:0]      r_len;
  logic [31:0]      r_crc;
  logic             r_ovf;
  logic             r_align;
  logic [CNT_W-1:0] r_succ_cnt;
  logic [CNT_W-1:0] r_bof_cnt;
  logic [CNT_W-1:0] r_crc_cnt;
  logic [CNT_W-1:0] r_len_cnt;

  logic [7:0]       w_sh_nxt;
  logic             w_byte_done;
  logic             w_crc_err;
  logic             w_len_err;
  logic             w_good;

  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'd0, b};
    for (int k = 0; k < 8; k++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction

  function automatic logic [CNT_W-1:0] to_gray(input logic [CNT_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // The wire bit order is LSB first, so new symbols enter at the top.
  assign w_sh_nxt    = {RXD, r_sh[7:DW]};
  assign w_byte_done = (r_phase == PH_LAST);
  assign w_crc_err   = (r_crc != CRC_RESIDUE);
  assign w_len_err   = (r_len < MIN_L) || (r_len > MAX_L);
  assign w_good      = !(r_ovf || r_align || w_len_err || w_crc_err);

  always_ff @(posedge REF_CLK or posedge arst) begin
    if (arst) begin
      r_state     <= S_IDLE;
      r_sh        <= 8'd0;
      r_phase     <= 2'd0;
      r_len       <= 11'd0;
      r_crc       <= 32'd0;
      r_ovf       <= 1'b0;
      r_align     <= 1'b0;
      r_succ_cnt  <= '0;
      r_bof_cnt   <= '0;
      r_crc_cnt   <= '0;
      r_len_cnt   <= '0;
      fifo_din    <= 8'd0;
      fifo_wren   <= 1'b0;
      fifo_EOD_in <= 1'b0;
    end else begin
      r_sh        <= w_sh_nxt;
      fifo_wren   <= 1'b0;
      fifo_EOD_in <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (CRS) begin
            if (fifo_afull) begin
              r_bof_cnt <= r_bof_cnt + CNT_W'(1);
              r_state   <= S_DROP;
            end else begin
              r_state <= S_PRE;
            end
          end
        end
        S_PRE: begin
          if (!CRS) begin
            r_state <= S_IDLE;
          end else if (w_sh_nxt == SFD) begin
            r_state <= S_BODY;
            r_phase <= 2'd0;
            r_crc   <= CRC_INIT;
            r_len   <= 11'd0;
            r_ovf   <= 1'b0;
            r_align <= 1'b0;
          end
        end
        S_BODY: begin
          r_phase <= w_byte_done ? 2'd0 : r_phase + 2'd1;
          if (w_byte_done && fifo_afull) begin
            r_ovf   <= 1'b1;
            r_state <= S_END;
          end else begin
            if (w_byte_done) begin
              fifo_din  <= w_sh_nxt;
              fifo_wren <= (r_len < MAX_L);
              r_len     <= (&r_len) ? r_len : r_len + 11'd1;
              r_crc     <= crc32_byte(r_crc, w_sh_nxt);
            end
            // A byte completing on the same edge as the carrier drop is whole.
            if (!CRS) begin
              r_align <= !w_byte_done && (r_phase != 2'd0);
              r_state <= S_END;
            end
          end
        end
        S_END: begin
          fifo_din    <= {4'b0000, r_ovf, r_align, w_len_err, w_crc_err};
          fifo_wren   <= 1'b1;
          fifo_EOD_in <= 1'b1;
          if (w_good)               r_succ_cnt <= r_succ_cnt + CNT_W'(1);
          if (w_crc_err)            r_crc_cnt  <= r_crc_cnt + CNT_W'(1);
          if (w_len_err || r_align) r_len_cnt  <= r_len_cnt + CNT_W'(1);
          if (r_ovf)                r_bof_cnt  <= r_bof_cnt + CNT_W'(1);
          r_state <= CRS ? S_DROP : S_IDLE;
        end
        S_DROP: begin
          if (!CRS) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Registered gray copies are the only counter view crossing to the user domain.
  always_ff @(posedge REF_CLK or posedge arst) begin
    if (arst) begin
      succ_rx_count_gray <= '0;
      buff_OF_count_gray <= '0;
      crc_err_count_gray <= '0;
      len_err_count_gray <= '0;
    end else begin
      succ_rx_count_gray <= to_gray(r_succ_cnt);
      buff_OF_count_gray <= to_gray(r_bof_cnt);
      crc_err_count_gray <= to_gray(r_crc_cnt);
      len_err_count_gray <= to_gray(r_len_cnt);
    end
  end

endmodule

// File: tb/tb_rmii_rx_framer.sv
// Directed frames into an RMII (DW=2) and an MII (DW=4) framer, checking FIFO
// writes, status trailers and the gray-coded monitor counters.
`timescale 1ns/1ps
module tb_rmii_rx_framer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        arst;
  logic        crs_a, afull_a, crs_b, afull_b;
  logic [1:0]  rxd_a;
  logic [3:0]  rxd_b;
  logic [7:0]  din_a, din_b;
  logic        wren_a, eod_a, wren_b, eod_b;
  logic [15:0] succ_a, bof_a, crce_a, lene_a;
  logic [15:0] succ_b, bof_b, crce_b, lene_b;

  rmii_rx_framer #(.DW(2), .MIN_LEN(64), .MAX_LEN(1518), .CNT_W(16)) dut_a (
    .REF_CLK(clk), .arst(arst), .CRS(crs_a), .RXD(rxd_a), .fifo_afull(afull_a),
    .fifo_din(din_a), .fifo_wren(wren_a), .fifo_EOD_in(eod_a),
    .succ_rx_count_gray(succ_a), .buff_OF_count_gray(bof_a),
    .crc_err_count_gray(crce_a), .len_err_count_gray(lene_a));

  rmii_rx_framer #(.DW(4), .MIN_LEN(64), .MAX_LEN(1518), .CNT_W(16)) dut_b (
    .REF_CLK(clk), .arst(arst), .CRS(crs_b), .RXD(rxd_b), .fifo_afull(afull_b),
    .fifo_din(din_b), .fifo_wren(wren_b), .fifo_EOD_in(eod_b),
    .succ_rx_count_gray(succ_b), .buff_OF_count_gray(bof_b),
    .crc_err_count_gray(crce_b), .len_err_count_gray(lene_b));

  int checks = 0;
  int errors = 0;

  logic [7:0] fb[$];
  logic [7:0] wa_d[$], wb_d[$];
  logic       wa_e[$], wb_e[$];

  typedef struct {
    bit         sel_b;
    int         plen;
    int         flip;
    int         extra;
    int         exp_n;
    logic [7:0] exp_tr;
  } vec_t;
  vec_t tbl[6];

  always @(negedge clk) begin
    if (wren_a) begin wa_d.push_back(din_a); wa_e.push_back(eod_a); end
    if (wren_b) begin wb_d.push_back(din_b); wb_e.push_back(eod_b); end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'd0, b};
    for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  task automatic build(input int plen, input int mult, input int base, input bit fcs, input int flip);
    logic [31:0] c;
    fb.delete();
    for (int i = 0; i < plen; i++) fb.push_back(8'((i * mult + base) & 255));
    if (fcs) begin
      c = 32'hFFFFFFFF;
      for (int i = 0; i < fb.size(); i++) c = crc_upd(c, fb[i]);
      c = ~c;
      fb.push_back(c[7:0]);   fb.push_back(c[15:8]);
      fb.push_back(c[23:16]); fb.push_back(c[31:24]);
    end
    if (flip >= 0) fb[flip] = fb[flip] ^ 8'h01;
  endtask

  task automatic pulse_rst();
    #1 arst = 1'b1;
    #1;
    chk("rst_now_din",  32'(din_a),  32'd0);
    chk("rst_now_wren", 32'(wren_a), 32'd0);
    chk("rst_now_eod",  32'(eod_a),  32'd0);
    chk("rst_now_bof",  32'(bof_a),  32'd0);
    chk("rst_now_cnt",  32'(succ_a | crce_a | lene_a | succ_b | bof_b | crce_b | lene_b), 32'd0);
    #6 arst = 1'b0;
  endtask

  task automatic send_byte(input bit sel_b, input logic [7:0] b, input bit af_first, input bit rst_first);
    int dw;
    logic [7:0] v;
    dw = sel_b ? 4 : 2;
    for (int k = 0; k < 8 / dw; k++) begin
      v = b >> (k * dw);
      @(negedge clk);
      if (sel_b) begin crs_b = 1'b1; rxd_b = v[3:0]; end
      else       begin crs_a = 1'b1; rxd_a = v[1:0]; end
      if (k == 0 && af_first) begin
        if (sel_b) afull_b = 1'b1; else afull_a = 1'b1;
      end
      if (k == 0 && rst_first) pulse_rst();
    end
  endtask

  task automatic send(input bit sel_b, input int extra, input int afull_at, input int rst_at);
    for (int p = 0; p < 8; p++) send_byte(sel_b, (p == 7) ? 8'hD5 : 8'h55, 1'b0, 1'b0);
    for (int i = 0; i < fb.size(); i++) send_byte(sel_b, fb[i], i == afull_at, i == rst_at);
    for (int x = 0; x < extra; x++) begin
      @(negedge clk);
      if (sel_b) rxd_b = 4'hF; else rxd_a = 2'b11;
    end
    @(negedge clk);
    if (sel_b) begin crs_b = 1'b0; rxd_b = 4'h0; end
    else       begin crs_a = 1'b0; rxd_a = 2'b00; end
    repeat (8) @(negedge clk);
    afull_a = 1'b0;
    afull_b = 1'b0;
  endtask

  task automatic check_frame(input bit sel_b, input string nm, input int exp_n, input int exp_eod,
                             input logic [7:0] exp_tr, input logic [7:0] tr_mask);
    int n_data, n_eod, bad, sz;
    logic [7:0] d, tr;
    logic e;
    n_data = 0; n_eod = 0; bad = 0; tr = 8'd0;
    sz = sel_b ? wb_d.size() : wa_d.size();
    for (int i = 0; i < sz; i++) begin
      d = sel_b ? wb_d[i] : wa_d[i];
      e = sel_b ? wb_e[i] : wa_e[i];
      if (e) begin
        n_eod++;
        tr = d;
      end else begin
        if (n_eod != 0 || i >= fb.size() || d !== fb[i]) bad++;
        n_data++;
      end
    end
    chk({nm, "_nwrites"}, 32'(n_data), 32'(exp_n));
    chk({nm, "_data"}, 32'(bad), 32'd0);
    chk({nm, "_eodcount"}, 32'(n_eod), 32'(exp_eod));
    chk({nm, "_trailer"}, 32'(tr & tr_mask), 32'(exp_tr));
    wa_d.delete(); wa_e.delete(); wb_d.delete(); wb_e.delete();
  endtask

  initial begin
    arst = 1'b1;
    crs_a = 1'b0; rxd_a = 2'b00; afull_a = 1'b0;
    crs_b = 1'b0; rxd_b = 4'h0;  afull_b = 1'b0;

    //              sel  plen  flip extra exp_n  trailer
    tbl[0] = '{1'b0,   60,  -1,  0,    64, 8'h00};
    tbl[1] = '{1'b0,   60,  10,  0,    64, 8'h01};
    tbl[2] = '{1'b0,   66,  -1,  1,    70, 8'h04};
    tbl[3] = '{1'b0,   59,  -1,  0,    63, 8'h02};
    tbl[4] = '{1'b1, 1514,  -1,  0,  1518, 8'h00};
    tbl[5] = '{1'b1, 1518,  -1,  0,  1518, 8'h02};

    repeat (3) @(negedge clk);
    chk("reset_din",  32'(din_a),  32'd0);
    chk("reset_wren", 32'(wren_a | wren_b), 32'd0);
    chk("reset_eod",  32'(eod_a | eod_b),   32'd0);
    chk("reset_cnts", 32'(succ_a | bof_a | crce_a | lene_a), 32'd0);
    #1 arst = 1'b0;
    repeat (3) @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      build(tbl[v].plen, 7, v * 13 + 1, 1'b1, tbl[v].flip);
      send(tbl[v].sel_b, tbl[v].extra, -1, -1);
      check_frame(tbl[v].sel_b, $sformatf("vec%0d", v), tbl[v].exp_n, 1, tbl[v].exp_tr, 8'hFF);
    end

    // gray(1)=1, gray(2)=3
    chk("succ_a", 32'(succ_a), 32'd1);
    chk("crce_a", 32'(crce_a), 32'd1);
    chk("lene_a", 32'(lene_a), 32'd3);
    chk("bof_a",  32'(bof_a),  32'd0);
    chk("succ_b", 32'(succ_b), 32'd1);
    chk("lene_b", 32'(lene_b), 32'd1);
    chk("crce_b", 32'(crce_b), 32'd0);

    // FIFO almost full when carrier rises: whole frame dropped.
    build(60, 7, 5, 1'b1, -1);
    afull_a = 1'b1;
    send(1'b0, 0, -1, -1);
    check_frame(1'b0, "afull_rise", 0, 0, 8'h00, 8'hFF);
    chk("bof_a_rise", 32'(bof_a), 32'd1);

    // FIFO almost full while byte 20 is arriving: 19 bytes, then ovf trailer.
    build(60, 7, 9, 1'b1, -1);
    send(1'b0, 0, 19, -1);
    check_frame(1'b0, "afull_b20", 19, 1, 8'h0A, 8'hFE);
    chk("bof_a_b20", 32'(bof_a), 32'd3);

    // Reset in the middle of byte 30: no trailer, then hunt until carrier drops.
    build(60, 0, 8'h0F, 1'b0, -1);
    send(1'b0, 0, -1, 29);
    check_frame(1'b0, "rst_frame", 29, 0, 8'h00, 8'hFF);
    chk("rst_cnts", 32'(succ_a | bof_a | crce_a | lene_a), 32'd0);

    build(60, 7, 21, 1'b1, -1);
    send(1'b0, 0, -1, -1);
    check_frame(1'b0, "after_rst", 64, 1, 8'h00, 8'hFF);
    chk("succ_after_rst", 32'(succ_a), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
